// File: rtl/runner_pkg.sv
// rtl/runner_pkg.sv - shared state encoding and width helpers for the runner controller
package runner_pkg;

  localparam int ST_W = 6;

  // One-hot game states; bit order matches the q_* decode outputs.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 6'b000001,
    ST_RUN   = 6'b000010,
    ST_JUMP  = 6'b000100,
    ST_DUCK  = 6'b001000,
    ST_PAUSE = 6'b010000,
    ST_OVER  = 6'b100000
  } state_t;

  localparam int IDLE_B  = 0;
  localparam int RUN_B   = 1;
  localparam int JUMP_B  = 2;
  localparam int DUCK_B  = 3;
  localparam int PAUSE_B = 4;
  localparam int OVER_B  = 5;

  // Signed vertical velocity needs one extra bit over the height to reach +/- full range.
  function automatic int vel_w(input int pos_w);
    return pos_w + 1;
  endfunction

endpackage

// File: rtl/runner_tick_gen.sv
// rtl/runner_tick_gen.sv - free-running prescaler producing the one-cycle game tick
module runner_tick_gen #(
  parameter int TICK_DIV = 65536
) (
  input  logic Clk,
  input  logic Reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1 in every game state and wrap.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/runner_ctrl.sv
// rtl/runner_ctrl.sv - runner game FSM with jump physics, scoring, speed ramp and high score
module runner_ctrl
  import runner_pkg::*;
#(
  parameter int POS_W         = 8,
  parameter int SCORE_W       = 16,
  parameter int SPEED_W       = 8,
  parameter int TICK_DIV      = 65536,
  parameter int JUMP_V0       = 20,
  parameter int GRAVITY       = 1,
  parameter int PTS_PER_SPEED = 100,
  parameter int MAX_SPEED     = 255
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Restart,
  input  logic               Jump,
  input  logic               Duck,
  input  logic               Pause,
  input  logic               hit_obs,
  output logic               q_Idle,
  output logic               q_Run,
  output logic               q_Jump,
  output logic               q_Duck,
  output logic               q_Pause,
  output logic               q_Over,
  output logic [POS_W-1:0]   y_pos,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [SPEED_W-1:0] speed,
  output logic               tick,
  output logic               new_hi
);

  localparam int VW    = vel_w(POS_W);
  localparam int PTS_W = $clog2(PTS_PER_SPEED + 1);

  state_t                     state;
  state_t                     resume_state;
  logic signed [VW-1:0]       vy;
  logic        [PTS_W-1:0]    pts;
  logic        [SCORE_W-1:0]  hi_snap;

  logic signed [VW:0]         y_sum;
  logic                       land;
  logic        [POS_W-1:0]    y_next;
  logic        [SCORE_W-1:0]  score_inc;
  logic        [SPEED_W-1:0]  speed_inc;
  logic                       pts_wrap;

  runner_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .Clk  (Clk),
    .Reset(Reset),
    .tick (tick)
  );

  // Next-tick physics and saturating counter candidates.
  always_comb begin
    y_sum     = $signed({2'b00, y_pos}) + $signed({vy[VW-1], vy});
    land      = vy[VW-1] && (y_sum[VW] || (y_sum == '0));
    y_next    = y_sum[POS_W-1:0];
    if (!y_sum[VW] && y_sum[POS_W]) begin
      y_next = '1;
    end
    score_inc = (score == '1) ? score : score + SCORE_W'(1);
    speed_inc = (speed >= SPEED_W'(MAX_SPEED)) ? speed : speed + SPEED_W'(1);
    pts_wrap  = (pts == PTS_W'(PTS_PER_SPEED - 1));
  end

  // Game FSM plus all registered game state; a hit always wins over pause and movement.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      resume_state <= ST_RUN;
      y_pos        <= '0;
      vy           <= '0;
      score        <= '0;
      hi_score     <= '0;
      hi_snap      <= '0;
      speed        <= '0;
      pts          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          score <= '0;
          speed <= SPEED_W'(1);
          y_pos <= '0;
          vy    <= '0;
          pts   <= '0;
          if (Start) begin
            state   <= ST_RUN;
            hi_snap <= hi_score;
          end
        end
        ST_RUN, ST_JUMP, ST_DUCK: begin
          if (hit_obs) begin
            state <= ST_OVER;
            if (score > hi_score) begin
              hi_score <= score;
            end
            if ((state == ST_JUMP) && tick && land) begin
              y_pos <= '0;
              vy    <= '0;
            end
          end else if (Pause) begin
            state        <= ST_PAUSE;
            resume_state <= state;
          end else begin
            if (tick) begin
              score <= score_inc;
              if (pts_wrap) begin
                pts   <= '0;
                speed <= speed_inc;
              end else begin
                pts <= pts + PTS_W'(1);
              end
            end
            case (state)
              ST_RUN: begin
                if (Jump) begin
                  state <= ST_JUMP;
                  vy    <= VW'(JUMP_V0);
                end else if (Duck) begin
                  state <= ST_DUCK;
                end
              end
              ST_DUCK: begin
                if (Jump) begin
                  state <= ST_JUMP;
                  vy    <= VW'(JUMP_V0);
                end else if (!Duck) begin
                  state <= ST_RUN;
                end
              end
              default: begin
                if (tick) begin
                  if (land) begin
                    y_pos <= '0;
                    vy    <= '0;
                    state <= Duck ? ST_DUCK : ST_RUN;
                  end else begin
                    y_pos <= y_next;
                    vy    <= vy - VW'(GRAVITY);
                  end
                end
              end
            endcase
          end
        end
        ST_PAUSE: begin
          if (!Pause) begin
            state <= resume_state;
          end
        end
        ST_OVER: begin
          if (Restart) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign q_Idle  = state[IDLE_B];
  assign q_Run   = state[RUN_B];
  assign q_Jump  = state[JUMP_B];
  assign q_Duck  = state[DUCK_B];
  assign q_Pause = state[PAUSE_B];
  assign q_Over  = state[OVER_B];
  assign new_hi  = !state[IDLE_B] && (score > hi_snap);

endmodule
